elevator_ctrl_nfloor: RTL
=========================

// Module: elevator_ctrl_nfloor
// PURPOSE
//  Parametrised N-floor elevator car controller; successor to the fixed 3-floor elevator.
//  Latches hall (up/down) and car (floor) requests, schedules them SCAN-style (keep direction while work remains ahead),
//  tracks car position from the floor sensor, drives motor direction and a timed door. Sits under the elevator_if bench harness.
// PARAMETERS
//  NUM_FLOORS        4   floors 0..NUM_FLOORS-1, >=2
//  DOOR_OPEN_CYCLES  8   clk cycles door stays open absent dc, >=2
//  FLOOR_W           $clog2(NUM_FLOORS)  derived; floor index width
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-low reset
//  up_req     in   NUM_FLOORS  hall up buttons, pulse or level; bit NUM_FLOORS-1 ignored
//  down_req   in   NUM_FLOORS  hall down buttons; bit 0 ignored
//  car_req    in   NUM_FLOORS  in-car floor buttons
//  dc         in   1           door-close button
//  fs_valid   in   1           floor sensor strobe, one cycle as car reaches a floor
//  fs         in   FLOOR_W     floor index qualified by fs_valid
//  door       out  1           1 = door open
//  direction  out  2           dir_t: 00 IDLE, 01 UP, 10 DOWN (11 never driven)
//  cur_floor  out  FLOOR_W     last accepted floor
//  pending    out  NUM_FLOORS  OR of latched up/down/car requests per floor
//  err        out  1           sticky sensor-fault flag
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, door=0, direction=IDLE, cur_floor=0, all request latches 0, err=0, timer 0.
//  Request latch: button high at edge -> latch set next cycle; cleared only when that floor is served (door opens there).
//  FSM IDLE -> MOVE_UP/MOVE_DOWN -> DOOR_OPEN -> IDLE|MOVE_*:
//   IDLE: request at cur_floor -> DOOR_OPEN next cycle (no latch visible); else any latch above -> MOVE_UP, else below -> MOVE_DOWN;
//         above and below both pending -> MOVE_UP.
//   MOVE_*: direction=UP/DOWN; on fs_valid with fs==cur_floor+/-1 update cur_floor same edge; stop (-> DOOR_OPEN) if
//         car_req or same-direction hall latch at that floor, or no latch further ahead and opposite hall latch there.
//   DOOR_OPEN: door=1, direction=IDLE, timer loads DOOR_OPEN_CYCLES, decrements each cycle; latches for cur_floor cleared on entry.
//         Exit when timer==0, or dc=1 after >=1 open cycle; new request at cur_floor while open reloads timer, never latched.
//         Exit: latch ahead in prior direction -> resume it; else opposite side -> reverse; else IDLE.
//  Latency: button->door open at current floor 2 cycles; fs_valid->door 1 cycle; dc->door=0 1 cycle.
//  Faults: fs_valid with fs>=NUM_FLOORS, fs not adjacent in travel direction, or fs_valid in IDLE/DOOR_OPEN -> ignored, err=1 sticky until reset.
//  Boundaries: never MOVE_UP at top floor / MOVE_DOWN at floor 0; button at floor being arrived on same edge as fs_valid is served by that stop.
//  Reset mid-move/mid-door: all state and latches discarded immediately.
// CONFIGURATION
//  ELEVATOR_OBSTRUCT_EN defined: adds input door_obstruct (1 bit); while door=1 and door_obstruct=1 timer holds at
//   DOOR_OPEN_CYCLES and dc ignored; door_obstruct rising while closing edge -> door stays 1.
//  Undefined: port absent; door timing per dc/timer only.
// STRUCTURE
//  elevator_pkg: dir_t enum (DIR_IDLE, DIR_UP, DIR_DOWN), ctrl_state_t enum (ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR_OPEN),
//   helper functions any_above(mask, floor), any_below(mask, floor).
//  Sub-module elevator_req_latch: per-floor up/down/car set/clear register bank, outputs pending and per-class masks.
//  Top: FSM, door timer, position tracking, err.
// TESTING (NUM_FLOORS=4, DOOR_OPEN_CYCLES=8)
//  Reset release, car_req[0] pulse at floor 0 -> door=1 two cycles later, door=0 after 8 open cycles, direction stays IDLE.
//  car_req[3] from floor 0; fs_valid fs=1,2,3 -> direction UP until fs=3, cur_floor 3, door=1 next cycle, pending=0.
//  Moving up from 0, up_req[2] and down_req[1] latched, car_req[3] -> stops at 2 and 3, then reverses, stops at 1.
//  Door open at floor 2, dc=1 on 3rd open cycle -> door=0 next cycle; car_req[2] during open -> timer reloads to 8.
//  fs_valid fs=3 while moving up from floor 0 -> ignored, err=1, cur_floor stays 0; rst=0 mid-move -> err=0, direction IDLE immediately.
//  ELEVATOR_OBSTRUCT_EN: door_obstruct=1 for 20 cycles with dc pulses -> door held 1; release -> closes 8 cycles later.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the N-floor elevator controller.
package elevator_pkg;

    localparam int unsigned MAX_FLOORS = 32;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } ctrl_state_t;

    // Strictly above / below the given floor; the floor itself is excluded.
    function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int unsigned floor);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++)
            if (i > floor && mask[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int unsigned floor);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++)
            if (i < floor && mask[i]) r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Per-floor hall-up / hall-down / car request bank; clear wins over set.
module elevator_req_latch #(
    parameter int NUM_FLOORS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_FLOORS-1:0] up_set_i,
    input  logic [NUM_FLOORS-1:0] dn_set_i,
    input  logic [NUM_FLOORS-1:0] car_set_i,
    input  logic [NUM_FLOORS-1:0] clr_i,
    output logic [NUM_FLOORS-1:0] up_o,
    output logic [NUM_FLOORS-1:0] dn_o,
    output logic [NUM_FLOORS-1:0] car_o,
    output logic [NUM_FLOORS-1:0] pending_o
);

    logic [NUM_FLOORS-1:0] up_q, up_d, dn_q, dn_d, car_q, car_d;

    always_comb begin
        up_d  = (up_q  | up_set_i)  & ~clr_i;
        dn_d  = (dn_q  | dn_set_i)  & ~clr_i;
        car_d = (car_q | car_set_i) & ~clr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_q  <= '0;
            dn_q  <= '0;
            car_q <= '0;
        end else begin
            up_q  <= up_d;
            dn_q  <= dn_d;
            car_q <= car_d;
        end
    end

    assign up_o      = up_q;
    assign dn_o      = dn_q;
    assign car_o     = car_q;
    assign pending_o = up_q | dn_q | car_q;

endmodule

// File: rtl/elevator_ctrl_nfloor.sv
// N-floor SCAN elevator controller: FSM, door timer, position tracking, sensor-fault flag.
// Optional ELEVATOR_OBSTRUCT_EN adds a door_obstruct input that holds the door open.
module elevator_ctrl_nfloor
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS       = 4,
    parameter int DOOR_OPEN_CYCLES = 8,
    parameter int FLOOR_W          = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] up_req,
    input  logic [NUM_FLOORS-1:0] down_req,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic                  dc,
`ifdef ELEVATOR_OBSTRUCT_EN
    input  logic                  door_obstruct,
`endif
    input  logic                  fs_valid,
    input  logic [FLOOR_W-1:0]    fs,
    output logic                  door,
    output logic [1:0]            direction,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  err
);

    localparam int TW = $clog2(DOOR_OPEN_CYCLES + 1);
    localparam logic [TW-1:0]         T_LOAD = TW'(DOOR_OPEN_CYCLES);
    localparam logic [FLOOR_W:0]      NF_W   = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] UP_OK  = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_OK  = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    ctrl_state_t           state_q, state_d;
    dir_t                  dir_q, dir_d, dir_out;
    logic [FLOOR_W-1:0]    cur_q, cur_d;
    logic [TW-1:0]         tmr_q, tmr_d, tmr_dec;
    logic                  err_q, err_d;
    logic [NUM_FLOORS-1:0] up_s_q, dn_s_q, car_s_q, clr;
    logic [NUM_FLOORS-1:0] up_l, dn_l, car_l;
    logic [NUM_FLOORS-1:0] all_s, all_e, up_a, dn_a, car_a, all_a;
    logic [FLOOR_W:0]      fl_up;
    logic                  up_hit, dn_hit, above_e, below_e, above_a, below_a, obstruct;

`ifdef ELEVATOR_OBSTRUCT_EN
    assign obstruct = door_obstruct;
`else
    assign obstruct = 1'b0;
`endif

    elevator_req_latch #(.NUM_FLOORS(NUM_FLOORS)) u_latch (
        .clk_i     (clk),
        .rst_ni    (rst),
        .up_set_i  (up_s_q),
        .dn_set_i  (dn_s_q),
        .car_set_i (car_s_q),
        .clr_i     (clr),
        .up_o      (up_l),
        .dn_o      (dn_l),
        .car_o     (car_l),
        .pending_o (pending)
    );

    // Buttons are sampled one cycle before they reach the latches, so a request
    // at an idle car's own floor opens the door without ever showing in pending.
    assign all_s = up_s_q | dn_s_q | car_s_q;
    assign all_e = up_l | dn_l | car_l | all_s;
    // Arrival check also sees buttons pressed on the arrival edge itself.
    assign up_a  = up_l  | up_s_q  | (up_req & UP_OK);
    assign dn_a  = dn_l  | dn_s_q  | (down_req & DN_OK);
    assign car_a = car_l | car_s_q | car_req;
    assign all_a = up_a | dn_a | car_a;

    assign fl_up   = {1'b0, cur_q} + (FLOOR_W + 1)'(1);
    assign up_hit  = fs_valid && ({1'b0, fs} == fl_up) && (fl_up < NF_W);
    assign dn_hit  = fs_valid && (cur_q != '0) && (fs == cur_q - FLOOR_W'(1));
    assign above_e = any_above(MAX_FLOORS'(all_e), 32'(cur_q));
    assign below_e = any_below(MAX_FLOORS'(all_e), 32'(cur_q));
    assign above_a = any_above(MAX_FLOORS'(all_a), 32'(fs));
    assign below_a = any_below(MAX_FLOORS'(all_a), 32'(fs));
    assign tmr_dec = tmr_q - TW'(1);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tmr_d   = tmr_q;
        dir_d   = dir_q;
        err_d   = err_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (fs_valid) err_d = 1'b1;
                if (all_e[cur_q])  state_d = ST_DOOR_OPEN;
                else if (above_e)  state_d = ST_MOVE_UP;
                else if (below_e)  state_d = ST_MOVE_DOWN;
            end
            ST_MOVE_UP: begin
                if (fs_valid && !up_hit) err_d = 1'b1;
                if (up_hit) begin
                    cur_d = fs;
                    if (car_a[fs] || up_a[fs] || (!above_a && dn_a[fs])) state_d = ST_DOOR_OPEN;
                    else if (!above_a)                                   state_d = ST_IDLE;
                end
            end
            ST_MOVE_DOWN: begin
                if (fs_valid && !dn_hit) err_d = 1'b1;
                if (dn_hit) begin
                    cur_d = fs;
                    if (car_a[fs] || dn_a[fs] || (!below_a && up_a[fs])) state_d = ST_DOOR_OPEN;
                    else if (!below_a)                                   state_d = ST_IDLE;
                end
            end
            ST_DOOR_OPEN: begin
                if (fs_valid) err_d = 1'b1;
                // Timer reaches zero on the exit edge: door is open DOOR_OPEN_CYCLES cycles.
                if (obstruct || all_s[cur_q]) begin
                    tmr_d = T_LOAD;
                end else if (dc || tmr_dec == '0) begin
                    tmr_d = '0;
                    if (dir_q == DIR_UP && above_e)        state_d = ST_MOVE_UP;
                    else if (dir_q == DIR_DOWN && below_e) state_d = ST_MOVE_DOWN;
                    else if (above_e)                      state_d = ST_MOVE_UP;
                    else if (below_e)                      state_d = ST_MOVE_DOWN;
                    else                                   state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_dec;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_DOOR_OPEN && state_d == ST_DOOR_OPEN) tmr_d = T_LOAD;
        if (state_d == ST_DOOR_OPEN) clr = NUM_FLOORS'(1) << cur_d;

        if (state_d == ST_MOVE_UP)        dir_d = DIR_UP;
        else if (state_d == ST_MOVE_DOWN) dir_d = DIR_DOWN;
        else if (state_d == ST_IDLE)      dir_d = DIR_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_IDLE;
            cur_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            up_s_q  <= '0;
            dn_s_q  <= '0;
            car_s_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cur_q   <= cur_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            up_s_q  <= up_req & UP_OK;
            dn_s_q  <= down_req & DN_OK;
            car_s_q <= car_req;
        end
    end

    always_comb begin
        dir_out = DIR_IDLE;
        if (state_q == ST_MOVE_UP)        dir_out = DIR_UP;
        else if (state_q == ST_MOVE_DOWN) dir_out = DIR_DOWN;
    end

    assign door      = (state_q == ST_DOOR_OPEN);
    assign direction = dir_out;
    assign cur_floor = cur_q;
    assign err       = err_q;

endmodule
